dmem_arbiter: RTL and testbench

Shares the single-port data RAM (data_mem_single) between the single-cycle RV32IM core's load/store port and a debug port. The debug port is used by a UART loader or display scanner to peek and poke RAM. The CPU has default priority. A starvation counter forces a one-cycle debug grant and stalls the CPU for that cycle; the top level uses `cpu_stall` to hold the PC register. The debug port uses a 4-phase req/ack handshake.

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, debug and RAM signals around the data-memory arbiter.
// slave: arbiter side. master: CPU / debug requester / RAM side.
interface dmem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic                  cpu_stall;

   logic                  dbg_req;
   logic                  dbg_we;
   logic [ADDR_WIDTH-1:0] dbg_addr;
   logic [DATA_WIDTH-1:0] dbg_wdata;
   logic                  dbg_ack;
   logic [DATA_WIDTH-1:0] dbg_rdata;

   logic                  mem_w_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_w_data;
   logic [DATA_WIDTH-1:0] mem_r_data;

   logic [15:0]           dbg_xfer_cnt;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ack, dbg_rdata,
      output mem_w_en, mem_addr, mem_w_data,
      input  mem_r_data,
      output dbg_xfer_cnt
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ack, dbg_rdata,
      input  mem_w_en, mem_addr, mem_w_data,
      output mem_r_data,
      input  dbg_xfer_cnt
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: CPU load/store port has priority, debug port (4-phase
// req/ack) is granted when the CPU is idle or after STARVE_MAX blocked cycles.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no debug request pending, CPU owns the RAM
// S_WAIT | debug request blocked by CPU traffic, r_wait_cnt counts it
// S_DBG  | one-cycle debug grant, RAM muxed to the debug port
// S_ACK  | debug done, dbg_ack high until dbg_req falls, CPU owns RAM
module dmem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int STARVE_MAX = 4    // 1..15, must fit the 4-bit wait counter
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DBG  = 2'd2,
      S_ACK  = 2'd3
   } state_t;

   localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

   state_t                r_state;
   logic [3:0]            r_wait_cnt;
   logic                  r_dbg_ack;
   logic [DATA_WIDTH-1:0] r_dbg_rdata;
   logic [15:0]           r_xfer_cnt;

   logic                  w_sel_dbg;
   logic                  w_mem_w_en;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_mem_w_data;

   assign w_sel_dbg = (r_state == S_DBG);

   // RAM port mux: debug owns the RAM only during the single S_DBG cycle
   always_comb begin
      w_mem_w_en   = bus.cpu_req & bus.cpu_we;
      w_mem_addr   = bus.cpu_addr;
      w_mem_w_data = bus.cpu_wdata;
      if (w_sel_dbg) begin
         w_mem_w_en   = bus.dbg_we;
         w_mem_addr   = bus.dbg_addr;
         w_mem_w_data = bus.dbg_wdata;
      end
   end

   // Gating with reset kills a pending write combinationally, before the edge
   assign bus.mem_w_en     = reset & w_mem_w_en;
   assign bus.mem_addr     = w_mem_addr;
   assign bus.mem_w_data   = w_mem_w_data;
   assign bus.cpu_rdata    = bus.mem_r_data;
   assign bus.cpu_stall    = reset & bus.cpu_req & w_sel_dbg;
   assign bus.dbg_ack      = r_dbg_ack;
   assign bus.dbg_rdata    = r_dbg_rdata;
   assign bus.dbg_xfer_cnt = r_xfer_cnt;

   // Arbitration FSM with registered ack, read data and transfer counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_wait_cnt  <= '0;
         r_dbg_ack   <= 1'b0;
         r_dbg_rdata <= '0;
         r_xfer_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.dbg_req) begin
                  if (bus.cpu_req) begin
                     r_state    <= S_WAIT;
                     r_wait_cnt <= 4'd1;
                  end else begin
                     r_state <= S_DBG;
                  end
               end
            end
            S_WAIT: begin
               if (!bus.dbg_req) begin
                  r_state    <= S_IDLE;
                  r_wait_cnt <= '0;
               end else if (!bus.cpu_req || (r_wait_cnt >= LP_STARVE_MAX)) begin
                  r_state <= S_DBG;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 4'd1;
               end
            end
            S_DBG: begin
               // Read data is captured before the write lands, so a read
               // sees the word as it was before this edge
               r_dbg_rdata <= bus.mem_r_data;
               r_state     <= S_ACK;
               r_wait_cnt  <= '0;
               r_dbg_ack   <= 1'b1;
               if (r_xfer_cnt != 16'hFFFF) begin
                  r_xfer_cnt <= r_xfer_cnt + 16'd1;
               end
            end
            S_ACK: begin
               if (!bus.dbg_req) begin
                  r_state   <= S_IDLE;
                  r_dbg_ack <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_dbg_ack <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM, directed debug/CPU traffic, and a
// scoreboard monitor that checks every dbg_ack rise against queued expectations.
module tb_dmem_arbiter;

   localparam int DW = 32;
   localparam int AW = 10;

   logic clk;
   logic reset;

   dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: combinational read, write on rising edge, preloaded once
   logic [DW-1:0] mem [0:(1<<AW)-1];
   bit            loaded = 1'b0;

   assign bus.mem_r_data = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
         mem[10'h010] <= 32'h1111_1111;
         mem[10'h020] <= 32'h2222_2222;
         mem[10'h040] <= 32'h7777_7777;
         mem[10'h050] <= 32'h0BAD_F00D;
         loaded <= 1'b1;
      end else if (bus.mem_w_en) begin
         mem[bus.mem_addr] <= bus.mem_w_data;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Activity counters sampled mid-cycle
   int stall_cnt = 0;
   int wen_cnt   = 0;
   always @(negedge clk) begin
      if (reset) begin
         if (bus.cpu_stall) stall_cnt++;
         if (bus.mem_w_en)  wen_cnt++;
      end
   end

   // Scoreboard
   typedef struct {
      logic [31:0] rdata;
      logic [15:0] cnt;
      int          ack_cyc;
   } exp_t;
   exp_t exp_q[$];
   logic prev_ack = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (bus.dbg_ack && !prev_ack) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_ack: dbg_ack rose at cycle %0d with nothing expected", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("ack_rdata", bus.dbg_rdata, e.rdata);
            chk("ack_xfer_cnt", 32'(bus.dbg_xfer_cnt), 32'(e.cnt));
            chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
         end
      end
      prev_ack = bus.dbg_ack;
   end

   logic [15:0] exp_cnt = '0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full debug handshake; cpu_* inputs are left as the caller set them
   task automatic dbg_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rdata, input int lat);
      exp_t e;
      bit   got;
      step();
      bus.dbg_we    = we;
      bus.dbg_addr  = addr;
      bus.dbg_wdata = wdata;
      bus.dbg_req   = 1'b1;
      exp_cnt       = exp_cnt + 16'd1;
      e.rdata   = exp_rdata;
      e.cnt     = exp_cnt;
      e.ack_cyc = cyc + lat;
      exp_q.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.cpu_stall) chk("stall_mem_addr", 32'(bus.mem_addr), 32'(addr));
         if (bus.dbg_ack) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL ack_timeout: no dbg_ack for addr 0x%03h", addr);
      end
      step();
      @(negedge clk);
      chk("ack_hold", 32'(bus.dbg_ack), 32'd1);
      bus.dbg_req = 1'b0;
      @(negedge clk);
      chk("ack_drop", 32'(bus.dbg_ack), 32'd0);
   endtask

   int s0, w0;

   initial begin
      reset         = 1'b0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 10'h123;
      bus.cpu_wdata = 32'h5555_AAAA;
      bus.dbg_req   = 1'b0;
      bus.dbg_we    = 1'b0;
      bus.dbg_addr  = '0;
      bus.dbg_wdata = '0;

      // Reset values with a CPU store pending
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_w_en", 32'(bus.mem_w_en), 32'd0);
      chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
      chk("rst_dbg_ack", 32'(bus.dbg_ack), 32'd0);
      chk("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
      chk("rst_xfer_cnt", 32'(bus.dbg_xfer_cnt), 32'd0);
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("idle_mem_addr", 32'(bus.mem_addr), 32'h123);
      chk("idle_mem_w_en", 32'(bus.mem_w_en), 32'd0);

      // Debug write with CPU idle
      s0 = stall_cnt; w0 = wen_cnt;
      dbg_txn(1'b1, 10'h010, 32'hDEAD_BEEF, 32'h1111_1111, 2);
      chk("wr_wen_cycles", 32'(wen_cnt - w0), 32'd1);
      chk("wr_stall_cycles", 32'(stall_cnt - s0), 32'd0);
      chk("wr_ram_word", mem[10'h010], 32'hDEAD_BEEF);

      // Debug read-back
      dbg_txn(1'b0, 10'h010, 32'h0, 32'hDEAD_BEEF, 2);

      // Starvation: CPU reading continuously
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 10'h300;
      s0 = stall_cnt; w0 = wen_cnt;
      dbg_txn(1'b0, 10'h010, 32'h0, 32'hDEAD_BEEF, 6);
      chk("starve_stall_cycles", 32'(stall_cnt - s0), 32'd1);
      chk("starve_wen_cycles", 32'(wen_cnt - w0), 32'd0);
      bus.cpu_req = 1'b0;

      // Contention ends early; CPU stores to 0x020 in the S_ACK cycle
      s0 = stall_cnt; w0 = wen_cnt;
      step();
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = 10'h030;
      bus.dbg_req   = 1'b1;
      bus.dbg_we    = 1'b0;
      bus.dbg_addr  = 10'h020;
      exp_cnt       = exp_cnt + 16'd1;
      exp_q.push_back('{32'h2222_2222, exp_cnt, cyc + 4});
      step();
      step();
      bus.cpu_req = 1'b0;
      step();
      @(negedge clk);
      chk("early_grant_mem_addr", 32'(bus.mem_addr), 32'h020);
      step();
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 10'h020;
      bus.cpu_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("ack_cycle_cpu_wen", 32'(bus.mem_w_en), 32'd1);
      chk("ack_cycle_cpu_dbg_ack", 32'(bus.dbg_ack), 32'd1);
      step();
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
      bus.dbg_req = 1'b0;
      chk("cpu_store_word", mem[10'h020], 32'hCAFE_F00D);
      chk("early_stall_cycles", 32'(stall_cnt - s0), 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("early_ack_drop", 32'(bus.dbg_ack), 32'd0);

      // Abort in S_WAIT
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 10'h031;
      w0 = wen_cnt;
      step();
      bus.dbg_req   = 1'b1;
      bus.dbg_we    = 1'b1;
      bus.dbg_addr  = 10'h040;
      bus.dbg_wdata = 32'h1234_5678;
      step();
      step();
      bus.dbg_req = 1'b0;
      repeat (4) step();
      chk("abort_wen_cycles", 32'(wen_cnt - w0), 32'd0);
      chk("abort_xfer_cnt", 32'(bus.dbg_xfer_cnt), 32'(exp_cnt));
      chk("abort_ram_word", mem[10'h040], 32'h7777_7777);
      chk("abort_dbg_ack", 32'(bus.dbg_ack), 32'd0);
      bus.cpu_req = 1'b0;
      dbg_txn(1'b0, 10'h040, 32'h0, 32'h7777_7777, 2);

      // Async reset while in S_DBG
      step();
      bus.dbg_req   = 1'b1;
      bus.dbg_we    = 1'b1;
      bus.dbg_addr  = 10'h050;
      bus.dbg_wdata = 32'hA5A5_A5A5;
      step();
      chk("dbg_cycle_wen", 32'(bus.mem_w_en), 32'd1);
      #2;
      reset         = 1'b0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 10'h050;
      bus.cpu_wdata = 32'hFFFF_FFFF;
      #1;
      chk("arst_mem_w_en", 32'(bus.mem_w_en), 32'd0);
      chk("arst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
      chk("arst_dbg_ack", 32'(bus.dbg_ack), 32'd0);
      chk("arst_dbg_rdata", bus.dbg_rdata, 32'd0);
      chk("arst_xfer_cnt", 32'(bus.dbg_xfer_cnt), 32'd0);
      bus.dbg_req = 1'b0;
      step();
      chk("arst_ram_word", mem[10'h050], 32'h0BAD_F00D);
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
      exp_cnt     = '0;
      step();
      reset = 1'b1;
      dbg_txn(1'b0, 10'h050, 32'h0, 32'h0BAD_F00D, 2);

      repeat (3) step();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
